// File: rtl/alu_request_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_request_arbiter_if
// Description : Request, ALU and response bundle shared by two requesters
//               and the ALU request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_request_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FUNC_WIDTH = 4
);
    logic [1:0]              _reqValid;
    logic [2*DATA_WIDTH-1:0] _reqValA;
    logic [2*DATA_WIDTH-1:0] _reqValB;
    logic [2*FUNC_WIDTH-1:0] _reqFunc;
    logic [1:0]              reqReady;
    logic [DATA_WIDTH-1:0]   aluValA;
    logic [DATA_WIDTH-1:0]   aluValB;
    logic [FUNC_WIDTH-1:0]   aluFunc;
    logic [DATA_WIDTH-1:0]   _aluResult;
    logic                    _aluOverflow;
    logic                    _aluCompare;
    logic [1:0]              respValid;
    logic [DATA_WIDTH-1:0]   respResult;
    logic                    respOverflow;
    logic                    respCompare;
    logic [1:0]              _respAccept;

    // Requester and ALU side of the bundle.
    modport master (
        output _reqValid, _reqValA, _reqValB, _reqFunc,
        input  reqReady,
        input  aluValA, aluValB, aluFunc,
        output _aluResult, _aluOverflow, _aluCompare,
        input  respValid, respResult, respOverflow, respCompare,
        output _respAccept
    );

    // Arbiter side of the bundle.
    modport slave (
        input  _reqValid, _reqValA, _reqValB, _reqFunc,
        output reqReady,
        output aluValA, aluValB, aluFunc,
        input  _aluResult, _aluOverflow, _aluCompare,
        output respValid, respResult, respOverflow, respCompare,
        input  _respAccept
    );
endinterface
`default_nettype wire

// File: rtl/alu_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_request_arbiter
// Description : Round-robin sequencer sharing one combinational ALU between
//               two requesters, one operation in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_request_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int FUNC_WIDTH = 4
) (
    input  wire logic           _clock,
    input  wire logic           _reset,
    alu_request_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_prio;
    logic                  r_owner;
    logic [DATA_WIDTH-1:0] r_aluValA;
    logic [DATA_WIDTH-1:0] r_aluValB;
    logic [FUNC_WIDTH-1:0] r_aluFunc;
    logic [DATA_WIDTH-1:0] r_respResult;
    logic                  r_respOverflow;
    logic                  r_respCompare;
    logic [1:0]            r_respValid;

    logic [1:0]            w_grant;
    logic                  w_grantIdx;
    logic                  w_transfer;
    logic [DATA_WIDTH-1:0] w_laneA;
    logic [DATA_WIDTH-1:0] w_laneB;
    logic [FUNC_WIDTH-1:0] w_laneFunc;

    // A lone requester always wins; a tie goes to the favoured one.
    always_comb begin
        w_grant = 2'b00;
        case (bus._reqValid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_prio ? 2'b10 : 2'b01;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_grantIdx   = w_grant[1];
    assign bus.reqReady = (r_state == IDLE && !_reset) ? w_grant : 2'b00;
    assign w_transfer   = |bus.reqReady;

    assign w_laneA    = w_grantIdx ? bus._reqValA[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : bus._reqValA[DATA_WIDTH-1:0];
    assign w_laneB    = w_grantIdx ? bus._reqValB[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : bus._reqValB[DATA_WIDTH-1:0];
    assign w_laneFunc = w_grantIdx ? bus._reqFunc[2*FUNC_WIDTH-1:FUNC_WIDTH]
                                   : bus._reqFunc[FUNC_WIDTH-1:0];

    always_ff @(posedge _clock) begin
        if (_reset) begin
            r_state        <= IDLE;
            r_prio         <= 1'b0;
            r_owner        <= 1'b0;
            r_aluValA      <= '0;
            r_aluValB      <= '0;
            r_aluFunc      <= '0;
            r_respResult   <= '0;
            r_respOverflow <= 1'b0;
            r_respCompare  <= 1'b0;
            r_respValid    <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_transfer) begin
                        r_aluValA <= w_laneA;
                        r_aluValB <= w_laneB;
                        r_aluFunc <= w_laneFunc;
                        r_owner   <= w_grantIdx;
                        r_prio    <= ~w_grantIdx;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable for a full cycle; sample the ALU.
                    r_respResult   <= bus._aluResult;
                    r_respOverflow <= bus._aluOverflow;
                    r_respCompare  <= bus._aluCompare;
                    r_respValid    <= r_owner ? 2'b10 : 2'b01;
                    r_state        <= RESP;
                end
                RESP: begin
                    if (bus._respAccept[r_owner]) begin
                        r_respValid <= 2'b00;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.aluValA      = r_aluValA;
    assign bus.aluValB      = r_aluValB;
    assign bus.aluFunc      = r_aluFunc;
    assign bus.respValid    = r_respValid;
    assign bus.respResult   = r_respResult;
    assign bus.respOverflow = r_respOverflow;
    assign bus.respCompare  = r_respCompare;
endmodule
`default_nettype wire

// File: tb/tb_alu_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_request_arbiter
// Description : Directed and randomized bench for alu_request_arbiter against
//               a transaction-level timing model; includes a reference ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_request_arbiter;
    localparam int DW = 16;
    localparam int FW = 4;
    localparam logic [FW-1:0] FUNC_ADD = 4'd0;
    localparam logic [FW-1:0] FUNC_SUB = 4'd1;
    localparam logic [FW-1:0] FUNC_AND = 4'd2;
    localparam logic [FW-1:0] FUNC_OR  = 4'd3;
    localparam logic [FW-1:0] FUNC_XOR = 4'd4;
    localparam logic [FW-1:0] FUNC_LSS = 4'd5;
    localparam logic [FW-1:0] FUNC_EQU = 4'd6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_request_arbiter_if #(.DATA_WIDTH(DW), .FUNC_WIDTH(FW)) bus ();

    alu_request_arbiter #(.DATA_WIDTH(DW), .FUNC_WIDTH(FW)) dut (
        ._clock (clk),
        ._reset (rst),
        .bus    (bus)
    );

    // Reference ALU: returns {overflow, compare, result}.
    function automatic logic [DW+1:0] aluRef(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [FW-1:0] f);
        logic [DW-1:0] r;
        logic ovf, cmp;
        r = '0; ovf = 1'b0; cmp = 1'b0;
        case (f)
            FUNC_ADD: begin r = a + b; ovf = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
            FUNC_SUB: begin r = a - b; ovf = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
            FUNC_AND: r = a & b;
            FUNC_OR:  r = a | b;
            FUNC_XOR: r = a ^ b;
            FUNC_LSS: cmp = $signed(a) < $signed(b);
            FUNC_EQU: cmp = (a == b);
            default:  r = '0;
        endcase
        return {ovf, cmp, r};
    endfunction

    logic [DW+1:0] aluOut;
    assign aluOut           = aluRef(bus.aluValA, bus.aluValB, bus.aluFunc);
    assign bus._aluResult   = aluOut[DW-1:0];
    assign bus._aluCompare  = aluOut[DW];
    assign bus._aluOverflow = aluOut[DW+1];

    int checks = 0;
    int failures = 0;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Stimulus state: one pending operation per requester, held until granted.
    bit            pend [2];
    logic [DW-1:0] pa [2];
    logic [DW-1:0] pb [2];
    logic [FW-1:0] pf [2];
    logic [1:0]    acc = 2'b00;

    // Transaction-level model: an issued operation occupies the ALU for one
    // cycle, then its response is visible until its owner accepts it.
    int            cyc = 0;
    bit            busy, prio, owner;
    int            tIssue;
    logic [DW-1:0] lastA, lastB;
    logic [FW-1:0] lastF;
    logic [DW+1:0] lastResp;
    int            grants[$];
    int            issues[$];
    bit            grantNow, done, gi;
    int            age;
    logic [1:0]    expReady, expResp;

    task automatic newOp(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [FW-1:0] f);
        pend[i] = 1'b1; pa[i] = a; pb[i] = b; pf[i] = f;
    endtask

    task automatic driveLanes();
        bus._reqValid   = {pend[1], pend[0]};
        bus._reqValA    = {pa[1], pa[0]};
        bus._reqValB    = {pb[1], pb[0]};
        bus._reqFunc    = {pf[1], pf[0]};
        bus._respAccept = acc;
    endtask

    task automatic stepCycle();
        driveLanes();
        @(negedge clk);
        grantNow = 1'b0; done = 1'b0; age = 0; expReady = 2'b00; expResp = 2'b00; gi = 1'b0;
        if (rst) begin
            checkValue("readyInReset", 32'(bus.reqReady), 32'd0);
            @(posedge clk);
            busy = 1'b0; prio = 1'b0; owner = 1'b0;
            lastA = '0; lastB = '0; lastF = '0; lastResp = '0;
        end else begin
            if (!busy) begin
                if (pend[0] && pend[1]) begin grantNow = 1'b1; gi = prio; end
                else if (pend[0])       begin grantNow = 1'b1; gi = 1'b0; end
                else if (pend[1])       begin grantNow = 1'b1; gi = 1'b1; end
                if (grantNow) expReady = gi ? 2'b10 : 2'b01;
            end else begin
                age = cyc - tIssue;
                if (age >= 2) begin
                    expResp = owner ? 2'b10 : 2'b01;
                    done = acc[owner];
                end
            end
            checkValue("reqReady", 32'(bus.reqReady), 32'(expReady));
            checkValue("respValid", 32'(bus.respValid), 32'(expResp));
            checkValue("aluValA", 32'(bus.aluValA), 32'(lastA));
            checkValue("aluValB", 32'(bus.aluValB), 32'(lastB));
            checkValue("aluFunc", 32'(bus.aluFunc), 32'(lastF));
            checkValue("respResult", 32'(bus.respResult), 32'(lastResp[DW-1:0]));
            checkValue("respCompare", 32'(bus.respCompare), 32'(lastResp[DW]));
            checkValue("respOverflow", 32'(bus.respOverflow), 32'(lastResp[DW+1]));
            @(posedge clk);
            if (grantNow) begin
                busy = 1'b1; tIssue = cyc; owner = gi; prio = ~gi;
                lastA = pa[gi]; lastB = pb[gi]; lastF = pf[gi];
                pend[gi] = 1'b0;
                grants.push_back(int'(gi));
                issues.push_back(cyc);
            end else if (busy) begin
                if (age == 1) lastResp = aluRef(lastA, lastB, lastF);
                if (done) busy = 1'b0;
            end
        end
        #1;
        cyc++;
    endtask

    task automatic drain();
        acc = 2'b11;
        for (int k = 0; k < 40 && (busy || pend[0] || pend[1]); k++) stepCycle();
        checkValue("drainTimeout", {30'd0, busy, pend[0] | pend[1]}, 32'd0);
    endtask

    int base;

    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin pa[i] = '0; pb[i] = '0; pf[i] = '0; end
        driveLanes();

        // Reset.
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        checkValue("rstRespValid", 32'(bus.respValid), 32'd0);
        checkValue("rstAluA", 32'(bus.aluValA), 32'd0);

        // Requester 0: 3 + 4.
        acc = 2'b11;
        newOp(0, 16'h0003, 16'h0004, FUNC_ADD);
        stepCycle();
        checkValue("addFuncAtExec", 32'(bus.aluFunc), 32'(FUNC_ADD));
        stepCycle();
        checkValue("addRespValid", 32'(bus.respValid), 32'h1);
        checkValue("addResult", 32'(bus.respResult), 32'h0007);
        checkValue("addOverflow", 32'(bus.respOverflow), 32'd0);
        drain();

        // Requester 1: signed overflow.
        newOp(1, 16'h7FFF, 16'h0001, FUNC_ADD);
        stepCycle();
        stepCycle();
        checkValue("ovfRespValid", 32'(bus.respValid), 32'h2);
        checkValue("ovfResult", 32'(bus.respResult), 32'h8000);
        checkValue("ovfOverflow", 32'(bus.respOverflow), 32'd1);
        drain();

        // Both continuously valid: alternating grants every 3 cycles.
        base = grants.size();
        newOp(0, 16'h0010, 16'h0001, FUNC_SUB);
        newOp(1, 16'h00F0, 16'h0F0F, FUNC_XOR);
        for (int k = 0; k < 30 && grants.size() < base + 4; k++) begin
            stepCycle();
            for (int i = 0; i < 2; i++)
                if (!pend[i] && grants.size() < base + 4) newOp(i, 16'(k + i), 16'h0005, FUNC_AND);
        end
        drain();
        for (int k = 0; k < 4; k++) begin
            checkValue("rrOrder", 32'(grants[base + k]), 32'(k % 2));
            if (k > 0) checkValue("rrInterval", 32'(issues[base + k] - issues[base + k - 1]), 32'd3);
        end

        // Held response, with requester 1 arriving during EXEC.
        acc = 2'b00;
        newOp(0, 16'hFFFF, 16'h0001, FUNC_LSS);
        stepCycle();
        newOp(1, 16'h1234, 16'h1234, FUNC_EQU);
        stepCycle();
        for (int k = 0; k < 5; k++) begin
            checkValue("holdRespValid", 32'(bus.respValid), 32'h1);
            checkValue("holdCompare", 32'(bus.respCompare), 32'd1);
            checkValue("holdResult", 32'(bus.respResult), 32'h0000);
            acc = 2'b10;
            stepCycle();
        end
        base = grants.size();
        acc = 2'b01;
        stepCycle();
        checkValue("notYetGranted", 32'(grants.size() - base), 32'd0);
        stepCycle();
        checkValue("pendingGranted", 32'(grants[grants.size() - 1]), 32'd1);
        drain();

        // Reset during RESP, then a tie grants requester 0.
        acc = 2'b00;
        newOp(1, 16'h0101, 16'h0202, FUNC_OR);
        stepCycle();
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkValue("rstMidRespValid", 32'(bus.respValid), 32'd0);
        checkValue("rstMidAluA", 32'(bus.aluValA), 32'd0);
        checkValue("rstMidAluFunc", 32'(bus.aluFunc), 32'd0);
        checkValue("rstMidResult", 32'(bus.respResult), 32'd0);
        pend[1] = 1'b0;
        newOp(0, 16'h0001, 16'h0001, FUNC_ADD);
        newOp(1, 16'h0002, 16'h0002, FUNC_ADD);
        stepCycle();
        checkValue("tieAfterReset", 32'(grants[grants.size() - 1]), 32'd0);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    newOp(i, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 6)));
            acc = 2'($urandom_range(0, 3));
            stepCycle();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_request_arbiter.md
# alu_request_arbiter

Two-requester round-robin arbiter and sequencer that shares the single combinational arithmeticLogicUnit between the execute stage (requester 0) and the address/branch unit (requester 1). It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and function ports from registers. It captures the ALU result, overflow and compare bits into registers and returns them to the granted requester over a valid/accept handshake.

## Interface
- DATA_WIDTH, 16, operand/result width (from definitions)
- FUNC_WIDTH, 4, function-code width (from definitions)

- _clock  input  1  sole clock, all state updates on rising edge
- _reset  input  1  synchronous, active-high reset
- _reqValid  input  2  bit i: requester i presents an operation
- _reqValA  input  2*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH], source A
- _reqValB  input  2*DATA_WIDTH  lane i, source B
- _reqFunc  input  2*FUNC_WIDTH  lane i = bits [i*FUNC_WIDTH +: FUNC_WIDTH], function code
- reqReady  output  2  bit i: operation from requester i is accepted this cycle
- aluValA  output  DATA_WIDTH  registered operand A to ALU
- aluValB  output  DATA_WIDTH  registered operand B to ALU
- aluFunc  output  FUNC_WIDTH  registered function code to ALU
- _aluResult  input  DATA_WIDTH  ALU result
- _aluOverflow  input  1  ALU overflow bit
- _aluCompare  input  1  ALU comparison bit
- respValid  output  2  one-hot; bit i: response for requester i is held
- respResult  output  DATA_WIDTH  captured result
- respOverflow  output  1  captured overflow
- respCompare  output  1  captured compare bit
- _respAccept  input  2  bit i: requester i consumes its response

## Operation
- States: IDLE, EXEC, RESP. The reset state is IDLE.
- Priority pointer `prio` (1 bit) names the favoured requester. Its reset value is 0.
- IDLE grant rules:
  - If exactly one of `_reqValid` is set, that requester is granted.
  - If both are set, requester `prio` is granted.
  - If neither is set, there is no grant.
- reqReady is combinational. It is nonzero only in IDLE and equals the one-hot grant. The transfer occurs on a cycle where both `_reqValid[i]` and `reqReady[i]` are high.
- On transfer:
  - The lane's A, B and func are latched into aluValA, aluValB and aluFunc.
  - Requester index i is latched into `owner`.
  - `prio` is set to the other requester (~i).
  - The state moves to EXEC.
- EXEC (exactly 1 cycle):
  - The ALU sees stable registered operands.
  - `_aluResult`, `_aluOverflow` and `_aluCompare` are captured into respResult, respOverflow and respCompare.
  - The state moves to RESP.
- RESP:
  - `respValid[owner]` is high and the other bit is low.
  - The response outputs hold stable until `_respAccept[owner]` is sampled high. The state then returns to IDLE.
  - `_respAccept` on the non-owner bit is ignored.
- aluValA, aluValB and aluFunc hold their last latched values outside EXEC. They change only on a transfer.
- A requester must hold `_reqValid` and its lane stable until accepted. The arbiter does not check this.
- When a requester is not granted, its `_reqValid` stays pending. No request is dropped.

## Timing
- Reset values: `state` = IDLE, `prio` = 0, `owner` = 0, aluValA = aluValB = 0, aluFunc = 0, respResult = 0, respOverflow = 0, respCompare = 0, respValid = 2'b00. reqReady = 2'b00 while `_reset` is high.
- Latency:
  - Transfer occurs at cycle T.
  - EXEC is at T+1.
  - respValid rises at T+2.
  - If `_respAccept` is high at T+2, the arbiter is back in IDLE at T+3, and the next transfer can happen at T+3.
- Minimum issue interval is 3 cycles. There is no pipelining and at most one operation is in flight.
- If `_respAccept` is already high when respValid rises, the response completes in that same cycle.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,… starting from requester 0 after reset.
- A new request arriving during EXEC or RESP is not acknowledged. It is granted in the next IDLE per `prio`.
- Reset asserted in any state takes effect on the next edge:
  - The in-flight operation is discarded and no response is produced.
  - All outputs take their reset values.
- A reset pulse lasts at least 1 cycle. The arbiter accepts a request on the first cycle after `_reset` deasserts.

## Test plan
- Reset, then requester 0 issues FUNC_ADD with A=0x0003, B=0x0004 -> reqReady=2'b01 at T, aluFunc=FUNC_ADD at T+1, and at T+2 respValid=2'b01, respResult=0x0007, respOverflow=0.
- Requester 1 issues FUNC_ADD with A=0x7FFF, B=0x0001 -> respValid=2'b10, respResult=0x8000, respOverflow=1.
- Both requesters are held valid for 4 operations, accepting immediately -> grant order 0,1,0,1 and transfers at T, T+3, T+6, T+9.
- Requester 0 issues FUNC_LSS with A=0xFFFF, B=0x0001, and `_respAccept` is held low for 5 cycles -> respValid=2'b01, respCompare=1 and respResult=0x0000, stable for 5 cycles; requester 1's pending request is not granted until the cycle after accept.
- Requester 1 asserts `_reqValid` during EXEC of a requester-0 operation -> reqReady stays 0 until IDLE, then requester 1 is granted.
- Reset is asserted during RESP -> next cycle respValid=0 and all registers are 0; after reset, a simultaneous request from both requesters grants requester 0.
